reg_scramble_ctrl: RTL

REG_SCRAMBLE_CTRL -- requirements
Module: reg_scramble_ctrl

---
 rtl/scramble_pkg.sv | 18 +
 rtl/reg_scramble_ctrl_bit_permute.sv | 38 +++
 rtl/reg_scramble_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/scramble_pkg.sv
// Shared defaults and FSM state encoding for the register-file scrambler.
package scramble_pkg;

  localparam int unsigned AW_DEF      = 5;
  localparam int unsigned DW_DEF      = 8;
  localparam int unsigned N_WORDS_DEF = 32;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_CAP,
    WR_SETUP,
    WR_STB,
    WR_HOLD,
    FINISH
  } state_t;

endpackage

// File: rtl/reg_scramble_ctrl_bit_permute.sv
// bit_permute: combinational interleaving bit shuffle of one data word.
// Forward: low bits fill even-from-top positions, high bits fill the gaps.
// With SCRAMBLE_UNDO_EN defined, input inv selects the exact inverse shuffle.
module bit_permute
  import scramble_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic [DW-1:0] in,
`ifdef SCRAMBLE_UNDO_EN
  input  logic          inv,
`endif
  output logic [DW-1:0] out
);

  logic use_inv;

`ifdef SCRAMBLE_UNDO_EN
  assign use_inv = inv;
`else
  assign use_inv = 1'b0;
`endif

  // Pairwise mapping: out[DW-1-2k] <-> in[k], out[DW-2-2k] <-> in[DW-1-k].
  always_comb begin
    out = '0;
    for (int unsigned k = 0; k < DW / 2; k++) begin
      if (use_inv) begin
        out[k]        = in[DW - 1 - 2 * k];
        out[DW-1-k]   = in[DW - 2 - 2 * k];
      end else begin
        out[DW-1-2*k] = in[k];
        out[DW-2-2*k] = in[DW - 1 - k];
      end
    end
  end

endmodule

// File: rtl/reg_scramble_ctrl.sv
// reg_scramble_ctrl: sweeps N_WORDS register-file words, reading each over
// the shared DATA bus, permuting it and writing it back (5 cycles per word).
// Optional macro SCRAMBLE_UNDO_EN adds MODE to select the inverse permutation.
module reg_scramble_ctrl
  import scramble_pkg::*;
#(
  parameter int unsigned AW      = AW_DEF,
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned N_WORDS = N_WORDS_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
`ifdef SCRAMBLE_UNDO_EN
  input  logic          MODE,
`endif
  output logic          BUSY,
  output logic          DONE,
  output logic [AW-1:0] ADDR,
  inout  wire  [DW-1:0] DATA,
  output logic          OE,
  output logic          WS,
  output logic          CS
);

  state_t        state, nstate;
  logic [DW-1:0] word_q;
  logic [DW-1:0] perm_word;
  logic          drive;
  logic          last;

  assign last = (ADDR == AW'(N_WORDS - 1));

`ifdef SCRAMBLE_UNDO_EN
  logic mode_q;

  bit_permute #(.DW(DW)) u_perm (
    .in  (word_q),
    .inv (mode_q),
    .out (perm_word)
  );
`else
  bit_permute #(.DW(DW)) u_perm (
    .in  (word_q),
    .out (perm_word)
  );
`endif

  assign DATA = drive ? perm_word : 'z;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= nstate;
  end

  // Address counter, captured word and (optional) direction latch.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ADDR   <= '0;
      word_q <= '0;
`ifdef SCRAMBLE_UNDO_EN
      mode_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (START) begin
          ADDR   <= '0;
`ifdef SCRAMBLE_UNDO_EN
          mode_q <= MODE;
`endif
        end
        RD_CAP:  word_q <= DATA;
        WR_HOLD: if (!last) ADDR <= ADDR + 1'b1;
        default: ;
      endcase
    end
  end

  // Next-state and bus control decode.
  always_comb begin
    nstate = state;
    BUSY   = 1'b1;
    DONE   = 1'b0;
    OE     = 1'b1;
    CS     = 1'b1;
    WS     = 1'b0;
    drive  = 1'b0;
    case (state)
      IDLE: begin
        BUSY = 1'b0;
        if (START) nstate = RD_ADDR;
      end
      RD_ADDR: begin
        CS     = 1'b0;
        nstate = RD_CAP;
      end
      RD_CAP: begin
        CS     = 1'b0;
        nstate = WR_SETUP;
      end
      WR_SETUP: begin
        CS     = 1'b0;
        OE     = 1'b0;
        drive  = 1'b1;
        nstate = WR_STB;
      end
      WR_STB: begin
        CS     = 1'b0;
        OE     = 1'b0;
        WS     = 1'b1;
        drive  = 1'b1;
        nstate = WR_HOLD;
      end
      WR_HOLD: begin
        CS     = 1'b0;
        OE     = 1'b0;
        drive  = 1'b1;
        nstate = last ? FINISH : RD_ADDR;
      end
      FINISH: begin
        DONE   = 1'b1;
        nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

endmodule
